edge_gen: RTL and testbench
===========================

# edge_gen

Digital edge synthesizer: the generating counterpart of the period estimator in the DPLL loop. It takes a high-time and a low-time in 6.6 fixed point, with units of clk cycles. It emits rise and fall edge timestamps on a free-running 12-bit 6.6 timebase. Its `edges1`/`edges2` outputs use exactly the format the period estimator consumes, so the two blocks can be looped back for self-test and DCO modelling.

## Interface
- No parameters. All widths are fixed at 12-bit, 6 integer + 6 fractional bits, LSB = 1/64 clk cycle.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  generation enable; sampled every cycle.
- `r2f_in`  in  12  requested high time (rise to fall), 6.6 cycles.
- `f2r_in`  in  12  requested low time (fall to rise), 6.6 cycles.
- `edges1`  out  12  timestamp of the most recent rise, 6.6.
- `edges2`  out  12  timestamp of the most recent fall, 6.6.
- `rise_v`  out  1  one-cycle pulse: `edges1` updated this cycle.
- `fall_v`  out  1  one-cycle pulse: `edges2` updated this cycle.
- `level`  out  1  synthesized clock level: 1 after a rise, 0 after a fall.
- `busy`  out  1  high while not in IDLE.

## Operation
- **Timebase `tb`** (12 bit)
  - Increments by 12'h040 (1.0 cycle) every clk.
  - Wraps modulo 4096.
  - Reset value 0.
- **Duration latches `lat_r2f` / `lat_f2r`**
  - Loaded from `r2f_in` / `f2r_in` only at IDLE start and at every generated rise.
  - Input changes mid-period take effect at the next rise.
  - Clamp: any value below 12'h040 (including 0) is latched as 12'h040. This guarantees at most one edge per clk.
- **Remaining-time counter `rem`** (13 bit, 6.6 with headroom)
  - Holds time from the start of the current cycle to the next edge.
  - Maximum value: 12'h03F + 12'hFFF, which fits in 13 bits.
- **State machine IDLE / HIGH / LOW**
  - IDLE:
    - If `en` = 1: latch durations, emit a rise with timestamp = `tb`, set `rem` = `lat_r2f`, go to HIGH.
    - Otherwise stay in IDLE.
  - HIGH:
    - If `rem` < 12'h040: emit a fall with timestamp = (`tb` + `rem`) mod 4096, set `rem` = `rem` + `lat_f2r` − 12'h040, go to LOW.
    - Else: `rem` −= 12'h040.
  - LOW, when `rem` < 12'h040:
    - If `en` = 1: re-latch durations (clamped), emit a rise with timestamp = (`tb` + `rem`) mod 4096, set `rem` = `rem` + new `lat_r2f` − 12'h040, go to HIGH.
    - If `en` = 0: no rise is emitted; go to IDLE.
  - LOW, otherwise: `rem` −= 12'h040.
- **`en` deassertion**
  - Never truncates a period. The current high and low phases complete, then the block stops at the next would-be rise.
  - Reasserting `en` in LOW before that point continues seamlessly.
- **Timestamp arithmetic:** 12-bit modulo 4096, with no saturation. The consumer differences timestamps modulo 4096.

## Timing
- All outputs are registered.
- An edge decided in cycle N (using `tb`_N) drives `rise_v`/`fall_v`, `edges1`/`edges2` and `level` in cycle N+1.
  - The timestamp refers to `tb`_N plus the fractional offset.
- **Start-up:** `en` sampled high in IDLE at cycle N → `rise_v` = 1 at N+1, `edges1` = `tb`_N.
- **Pulse and hold behaviour**
  - `rise_v` and `fall_v` are never high in the same cycle.
  - Each pulse lasts exactly 1 cycle.
  - `edges1` and `edges2` hold their values between events.
- **`busy`:** goes high in the cycle of the start rise pulse; goes low the cycle after the IDLE transition.
- **Reset**
  - While `rst` = 1, all state clears at the next clk edge: state = IDLE, `tb` = 0, `rem` = 0, latches = 12'h040, `edges1` = `edges2` = 0, `rise_v` = `fall_v` = `level` = `busy` = 0.
  - Reset mid-operation aborts the period immediately. No pending edge is emitted.
  - `rst` has priority over `en`.
- **After reset release:** with `en` held high, the first rise occurs with timestamp 12'h040 × k, where k = cycles since release.

## Test plan
- **Integer period.** Reset release with `en` = 1 at `tb` = 0, `r2f_in` = 12'h080, `f2r_in` = 12'h0C0 → rises at 12'h000 and 12'h140, fall at 12'h080. Five-cycle period; `level` high for 2 cycles and low for 3.
- **Fractional period.** `r2f_in` = 12'h060, `f2r_in` = 12'h0A0 → rise 12'h000, fall 12'h060, rise 12'h100, fall 12'h160, rise 12'h200.
  - Loop back into the period estimator: measured high/low times converge to 12'h060 / 12'h0A0.
- **Clamp.** `r2f_in` = 12'h010, `f2r_in` = 0 → both latched as 12'h040. Alternating rise and fall every cycle; never two pulses in one cycle.
- **Wrap-around.** Rise timestamp 12'hFC0 with `r2f` = 12'h080 → fall timestamp 12'h040. The next rise follows `f2r` correctly across the `tb` wrap.
- **Mid-period input change and `en` drop.**
  - Change `r2f_in` while in HIGH → the current fall is unaffected; the new value applies after the next rise.
  - Drop `en` in HIGH → the fall is still emitted, no further rise is emitted, `busy` falls.
- **Reset mid-HIGH.** Assert `rst` for 1 cycle → next cycle `level` = 0, `edges1` = `edges2` = 0, no `fall_v`, state IDLE.

Source files
------------

// File: rtl/edge_gen.sv
// ---------------------------------------------------------------------------
// edge_gen
//
// Digital edge synthesizer. Produces rise and fall edge timestamps on a
// free-running 12-bit 6.6 fixed-point timebase. The high and low times are
// requested in clk cycles (6.6 fixed point, LSB = 1/64 cycle). The output
// format matches what the period estimator consumes, so the two blocks can
// be looped back for self-test and DCO modelling.
//
// Ports
//   clk     in   1   system clock
//   rst     in   1   synchronous active-high reset
//   en      in   1   generation enable, sampled every cycle
//   r2f_in  in  12   requested high time (rise to fall), 6.6 cycles
//   f2r_in  in  12   requested low time (fall to rise), 6.6 cycles
//   edges1  out 12   timestamp of the most recent rise, 6.6
//   edges2  out 12   timestamp of the most recent fall, 6.6
//   rise_v  out  1   one-cycle pulse: edges1 updated this cycle
//   fall_v  out  1   one-cycle pulse: edges2 updated this cycle
//   level   out  1   synthesized clock level (1 after rise, 0 after fall)
//   busy    out  1   high while the generator is not idle
// ---------------------------------------------------------------------------
module edge_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] r2f_in,
  input  logic [11:0] f2r_in,
  output logic [11:0] edges1,
  output logic [11:0] edges2,
  output logic        rise_v,
  output logic        fall_v,
  output logic        level,
  output logic        busy
);

  // One clk cycle in 6.6 fixed point.
  localparam logic [11:0] ONE_CYC   = 12'h040;
  localparam logic [12:0] ONE_CYC13 = 13'h0040;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t      state, state_nx;
  logic [11:0] tb;
  logic [12:0] rem, rem_nx;
  logic [11:0] lat_r2f, lat_f2r;
  logic [11:0] lat_r2f_nx, lat_f2r_nx;
  logic [11:0] r2f_clamped, f2r_clamped;
  logic [11:0] edge_ts;
  logic        rem_lt_one;
  logic        rise_nx, fall_nx;

  // Durations shorter than one cycle are raised to one cycle, which keeps
  // the generator to at most one edge per clk.
  assign r2f_clamped = (r2f_in < ONE_CYC) ? ONE_CYC : r2f_in;
  assign f2r_clamped = (f2r_in < ONE_CYC) ? ONE_CYC : f2r_in;

  // rem is the distance from the start of the current cycle to the next
  // edge, so an edge lands inside this cycle once it drops below one cycle.
  assign rem_lt_one = (rem < ONE_CYC13);

  // Edge timestamp: current timebase plus the sub-cycle offset. When an edge
  // is emitted rem is below one cycle, so its low 12 bits carry the offset.
  // The start-up rise from IDLE lands exactly on the current timebase.
  assign edge_ts = (state == IDLE) ? tb : (tb + rem[11:0]);

  // Next-state logic. After an edge, rem is re-based to the start of the
  // following cycle, hence the subtraction of one cycle whenever a new
  // duration is added in. The start rise sits at offset 0, so its high
  // phase starts as (r2f - 1 cycle); clamping keeps that non-negative.
  always_comb begin
    state_nx   = state;
    rem_nx     = rem;
    lat_r2f_nx = lat_r2f;
    lat_f2r_nx = lat_f2r;
    rise_nx    = 1'b0;
    fall_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          lat_r2f_nx = r2f_clamped;
          lat_f2r_nx = f2r_clamped;
          rise_nx    = 1'b1;
          rem_nx     = {1'b0, r2f_clamped} - ONE_CYC13;
          state_nx   = HIGH;
        end
      end
      HIGH: begin
        if (rem_lt_one) begin
          fall_nx  = 1'b1;
          rem_nx   = rem + {1'b0, lat_f2r} - ONE_CYC13;
          state_nx = LOW;
        end else begin
          rem_nx = rem - ONE_CYC13;
        end
      end
      LOW: begin
        if (rem_lt_one) begin
          if (en) begin
            lat_r2f_nx = r2f_clamped;
            lat_f2r_nx = f2r_clamped;
            rise_nx    = 1'b1;
            rem_nx     = rem + {1'b0, r2f_clamped} - ONE_CYC13;
            state_nx   = HIGH;
          end else begin
            // Period finished with en low: stop at the would-be rise.
            rem_nx   = '0;
            state_nx = IDLE;
          end
        end else begin
          rem_nx = rem - ONE_CYC13;
        end
      end
      default: begin
        rem_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // State, timebase and registered outputs. Reset wins over everything and
  // discards any edge that was about to be emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tb      <= '0;
      rem     <= '0;
      lat_r2f <= ONE_CYC;
      lat_f2r <= ONE_CYC;
      edges1  <= '0;
      edges2  <= '0;
      rise_v  <= 1'b0;
      fall_v  <= 1'b0;
      level   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      tb      <= tb + ONE_CYC;
      rem     <= rem_nx;
      lat_r2f <= lat_r2f_nx;
      lat_f2r <= lat_f2r_nx;
      rise_v  <= rise_nx;
      fall_v  <= fall_nx;
      busy    <= (state_nx != IDLE);
      if (rise_nx) begin
        edges1 <= edge_ts;
        level  <= 1'b1;
      end
      if (fall_nx) begin
        edges2 <= edge_ts;
        level  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_edge_gen.sv
// ---------------------------------------------------------------------------
// tb_edge_gen
//
// Directed self-checking bench for edge_gen. Each scenario task resets the
// DUT, drives inputs on the falling clock edge and compares the registered
// outputs one cycle at a time against a hand-computed table. A table row
// packs {rise_v, fall_v, level, busy, edges1, edges2}.
// ---------------------------------------------------------------------------
module tb_edge_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] r2f_in;
  logic [11:0] f2r_in;
  logic [11:0] edges1;
  logic [11:0] edges2;
  logic        rise_v;
  logic        fall_v;
  logic        level;
  logic        busy;

  int errors = 0;
  int checks = 0;

  edge_gen dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .r2f_in (r2f_in),
    .f2r_in (f2r_in),
    .edges1 (edges1),
    .edges2 (edges2),
    .rise_v (rise_v),
    .fall_v (fall_v),
    .level  (level),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are stable at the falling edge.
  task automatic step;
    @(negedge clk);
  endtask

  // Leaves the DUT in cycle 0 after reset (timebase 0), at a falling edge.
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [27:0] row(input logic [3:0] flags,
                                      input logic [11:0] e1,
                                      input logic [11:0] e2);
    return {flags, e1, e2};
  endfunction

  function automatic logic [27:0] observed();
    return {rise_v, fall_v, level, busy, edges1, edges2};
  endfunction

  task automatic test_reset;
    logic [27:0] got;
    rst    = 1'b1;
    en     = 1'b1;
    r2f_in = 12'h080;
    f2r_in = 12'h080;
    @(negedge clk);
    got = observed();
    checks++;
    if (got !== 28'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h, want %h", got, 28'h0);
    end
    // Reset held with en high: reset must still dominate.
    @(negedge clk);
    got = observed();
    checks++;
    if (got !== 28'h0) begin
      errors++;
      $display("[TB] FAIL reset_priority: got %h, want %h", got, 28'h0);
    end
  endtask

  task automatic test_integer_period;
    logic [27:0] tbl [6];
    logic [27:0] got;
    tbl[0] = row(4'b1011, 12'h000, 12'h000);
    tbl[1] = row(4'b0011, 12'h000, 12'h000);
    tbl[2] = row(4'b0101, 12'h000, 12'h080);
    tbl[3] = row(4'b0001, 12'h000, 12'h080);
    tbl[4] = row(4'b0001, 12'h000, 12'h080);
    tbl[5] = row(4'b1011, 12'h140, 12'h080);
    do_reset;
    r2f_in = 12'h080;
    f2r_in = 12'h0C0;
    en     = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step;
      got = observed();
      checks++;
      if (got !== tbl[k]) begin
        errors++;
        $display("[TB] FAIL integer_period cycle %0d: got rflb=%b e1=%h e2=%h, want rflb=%b e1=%h e2=%h",
                 k + 1, got[27:24], got[23:12], got[11:0],
                 tbl[k][27:24], tbl[k][23:12], tbl[k][11:0]);
      end
    end
  endtask

  task automatic test_fractional_period;
    logic [27:0] tbl [9];
    logic [27:0] got;
    tbl[0] = row(4'b1011, 12'h000, 12'h000);
    tbl[1] = row(4'b0101, 12'h000, 12'h060);
    tbl[2] = row(4'b0001, 12'h000, 12'h060);
    tbl[3] = row(4'b0001, 12'h000, 12'h060);
    tbl[4] = row(4'b1011, 12'h100, 12'h060);
    tbl[5] = row(4'b0101, 12'h100, 12'h160);
    tbl[6] = row(4'b0001, 12'h100, 12'h160);
    tbl[7] = row(4'b0001, 12'h100, 12'h160);
    tbl[8] = row(4'b1011, 12'h200, 12'h160);
    do_reset;
    r2f_in = 12'h060;
    f2r_in = 12'h0A0;
    en     = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step;
      got = observed();
      checks++;
      if (got !== tbl[k]) begin
        errors++;
        $display("[TB] FAIL fractional_period cycle %0d: got rflb=%b e1=%h e2=%h, want rflb=%b e1=%h e2=%h",
                 k + 1, got[27:24], got[23:12], got[11:0],
                 tbl[k][27:24], tbl[k][23:12], tbl[k][11:0]);
      end
    end
  endtask

  task automatic test_clamp;
    logic [27:0] tbl [6];
    logic [27:0] got;
    tbl[0] = row(4'b1011, 12'h000, 12'h000);
    tbl[1] = row(4'b0101, 12'h000, 12'h040);
    tbl[2] = row(4'b1011, 12'h080, 12'h040);
    tbl[3] = row(4'b0101, 12'h080, 12'h0C0);
    tbl[4] = row(4'b1011, 12'h100, 12'h0C0);
    tbl[5] = row(4'b0101, 12'h100, 12'h140);
    do_reset;
    r2f_in = 12'h010;
    f2r_in = 12'h000;
    en     = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step;
      got = observed();
      checks++;
      if (got !== tbl[k]) begin
        errors++;
        $display("[TB] FAIL clamp cycle %0d: got rflb=%b e1=%h e2=%h, want rflb=%b e1=%h e2=%h",
                 k + 1, got[27:24], got[23:12], got[11:0],
                 tbl[k][27:24], tbl[k][23:12], tbl[k][11:0]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [27:0] tbl [6];
    logic [27:0] got;
    tbl[0] = row(4'b1011, 12'hFC0, 12'h000);
    tbl[1] = row(4'b0011, 12'hFC0, 12'h000);
    tbl[2] = row(4'b0101, 12'hFC0, 12'h040);
    tbl[3] = row(4'b0001, 12'hFC0, 12'h040);
    tbl[4] = row(4'b0001, 12'hFC0, 12'h040);
    tbl[5] = row(4'b1011, 12'h100, 12'h040);
    do_reset;
    r2f_in = 12'h080;
    f2r_in = 12'h0C0;
    // Idle until cycle 63, where the timebase reads 12'hFC0.
    repeat (63) step;
    got = observed();
    checks++;
    if (got !== 28'h0) begin
      errors++;
      $display("[TB] FAIL wrap_idle: got %h, want %h", got, 28'h0);
    end
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step;
      got = observed();
      checks++;
      if (got !== tbl[k]) begin
        errors++;
        $display("[TB] FAIL wrap cycle %0d: got rflb=%b e1=%h e2=%h, want rflb=%b e1=%h e2=%h",
                 k + 1, got[27:24], got[23:12], got[11:0],
                 tbl[k][27:24], tbl[k][23:12], tbl[k][11:0]);
      end
    end
  endtask

  // r2f changes in the first HIGH (fall unaffected, new value used from the
  // next rise); en then drops in the second HIGH (fall kept, no new rise).
  task automatic test_mid_change_en_drop;
    logic [27:0] tbl [14];
    logic [27:0] got;
    tbl[0]  = row(4'b1011, 12'h000, 12'h000);
    tbl[1]  = row(4'b0011, 12'h000, 12'h000);
    tbl[2]  = row(4'b0101, 12'h000, 12'h080);
    tbl[3]  = row(4'b0001, 12'h000, 12'h080);
    tbl[4]  = row(4'b0001, 12'h000, 12'h080);
    tbl[5]  = row(4'b1011, 12'h140, 12'h080);
    tbl[6]  = row(4'b0011, 12'h140, 12'h080);
    tbl[7]  = row(4'b0011, 12'h140, 12'h080);
    tbl[8]  = row(4'b0011, 12'h140, 12'h080);
    tbl[9]  = row(4'b0101, 12'h140, 12'h240);
    tbl[10] = row(4'b0001, 12'h140, 12'h240);
    tbl[11] = row(4'b0001, 12'h140, 12'h240);
    tbl[12] = row(4'b0000, 12'h140, 12'h240);
    tbl[13] = row(4'b0000, 12'h140, 12'h240);
    do_reset;
    r2f_in = 12'h080;
    f2r_in = 12'h0C0;
    en     = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step;
      got = observed();
      checks++;
      if (got !== tbl[k]) begin
        errors++;
        $display("[TB] FAIL mid_change_en_drop cycle %0d: got rflb=%b e1=%h e2=%h, want rflb=%b e1=%h e2=%h",
                 k + 1, got[27:24], got[23:12], got[11:0],
                 tbl[k][27:24], tbl[k][23:12], tbl[k][11:0]);
      end
      if (k == 0) r2f_in = 12'h100;
      if (k == 6) en = 1'b0;
    end
  endtask

  task automatic test_reset_mid_high;
    logic [27:0] got;
    do_reset;
    r2f_in = 12'h100;
    f2r_in = 12'h040;
    en     = 1'b1;
    step;
    got = observed();
    checks++;
    if (got !== row(4'b1011, 12'h000, 12'h000)) begin
      errors++;
      $display("[TB] FAIL reset_mid_high_start: got %h, want %h", got, row(4'b1011, 12'h000, 12'h000));
    end
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    en  = 1'b0;
    got = observed();
    checks++;
    if (got !== 28'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_high_clear: got %h, want %h", got, 28'h0);
    end
    // The aborted fall must not appear afterwards.
    step;
    got = observed();
    checks++;
    if (got !== 28'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_high_no_fall: got %h, want %h", got, 28'h0);
    end
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    r2f_in = 12'h040;
    f2r_in = 12'h040;
    test_reset;
    test_integer_period;
    test_fractional_period;
    test_clamp;
    test_wrap;
    test_mid_change_en_drop;
    test_reset_mid_high;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
